// File: rtl/wf_zoom_ctrl.sv
// Waveform-window zoom controller: edge-detected buttons select a zoom stage,
// and the displayed window bounds slew toward that stage's target once per frame.
module wf_zoom_ctrl #(
  parameter int unsigned NUM_STAGES = 6,
  parameter int unsigned DEF_SX     = 380,
  parameter int unsigned DEF_EX     = 640,
  parameter int unsigned DEF_SY     = 92,
  parameter int unsigned DEF_EY     = 452,
  parameter int unsigned MAX_SX     = 88,
  parameter int unsigned MAX_EX     = 888,
  parameter int unsigned MAX_SY     = 30,
  parameter int unsigned MAX_EY     = 512,
  parameter int unsigned STEP_X     = 20,
  parameter int unsigned STEP_Y     = 12,
  parameter int unsigned SLEW       = 4,
  parameter int unsigned STAGE_W    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up,
  input  logic               btn_tog,
  input  logic               btn_dn,
  input  logic               frame_tick,
  output logic [10:0]        start_x,
  output logic [10:0]        end_x,
  output logic [9:0]         start_y,
  output logic [9:0]         end_y,
  output logic [STAGE_W-1:0] stage,
  output logic               busy
);

  localparam logic [STAGE_W-1:0] TOP = STAGE_W'(NUM_STAGES - 1);

  logic               up_q, tog_q, dn_q;
  logic               up_prev, tog_prev, dn_prev;
  logic               ev_up, ev_tog, ev_dn;
  logic [STAGE_W-1:0] stage_q, stage_nxt;
  logic [11:0]        kx, ky;
  logic [10:0]        tsx, tex, tgt_sx, tgt_ex, cur_sx, cur_ex, nsx, nex;
  logic [9:0]         tsy, tey, tgt_sy, tgt_ey, cur_sy, cur_ey, nsy, ney;

  // Move cur toward tgt by at most SLEW without overshooting.
  function automatic logic [11:0] slew_step(input logic [11:0] cur, input logic [11:0] tgt);
    logic [11:0] d;
    if (tgt > cur) begin
      d = tgt - cur;
      slew_step = (d > 12'(SLEW)) ? cur + 12'(SLEW) : tgt;
    end else begin
      d = cur - tgt;
      slew_step = (d > 12'(SLEW)) ? cur - 12'(SLEW) : tgt;
    end
  endfunction

  // Buttons pass through a sampling register first, so a rise sampled at edge N
  // acts on the stage at edge N+1.
  assign ev_up  = up_q  & ~up_prev;
  assign ev_tog = tog_q & ~tog_prev;
  assign ev_dn  = dn_q  & ~dn_prev;

  always_comb begin
    stage_nxt = stage_q;
    case ({ev_up, ev_tog, ev_dn})
      3'b100:  stage_nxt = (stage_q == TOP) ? '0 : stage_q + 1'b1;
      3'b010:  stage_nxt = (stage_q == '0) ? TOP : '0;
      3'b001:  if (stage_q != '0) stage_nxt = stage_q - 1'b1;
      default: stage_nxt = stage_q;
    endcase
  end

  always_comb begin
    kx = 12'(stage_nxt) * 12'(STEP_X);
    ky = 12'(stage_nxt) * 12'(STEP_Y);
    if (stage_nxt == '0) begin
      tsx = 11'(DEF_SX);
      tex = 11'(DEF_EX);
      tsy = 10'(DEF_SY);
      tey = 10'(DEF_EY);
    end else if (stage_nxt == TOP) begin
      tsx = 11'(MAX_SX);
      tex = 11'(MAX_EX);
      tsy = 10'(MAX_SY);
      tey = 10'(MAX_EY);
    end else begin
      tsx = 11'(12'(DEF_SX) - kx);
      tex = 11'(12'(DEF_EX) + kx);
      tsy = 10'(12'(DEF_SY) - ky);
      tey = 10'(12'(DEF_EY) + ky);
    end
  end

  always_comb begin
    nsx = 11'(slew_step({1'b0, cur_sx}, {1'b0, tgt_sx}));
    nex = 11'(slew_step({1'b0, cur_ex}, {1'b0, tgt_ex}));
    nsy = 10'(slew_step({2'b0, cur_sy}, {2'b0, tgt_sy}));
    ney = 10'(slew_step({2'b0, cur_ey}, {2'b0, tgt_ey}));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      up_q     <= 1'b1;
      tog_q    <= 1'b1;
      dn_q     <= 1'b1;
      up_prev  <= 1'b1;
      tog_prev <= 1'b1;
      dn_prev  <= 1'b1;
      stage_q  <= '0;
      tgt_sx   <= 11'(DEF_SX);
      tgt_ex   <= 11'(DEF_EX);
      tgt_sy   <= 10'(DEF_SY);
      tgt_ey   <= 10'(DEF_EY);
      cur_sx   <= 11'(DEF_SX);
      cur_ex   <= 11'(DEF_EX);
      cur_sy   <= 10'(DEF_SY);
      cur_ey   <= 10'(DEF_EY);
    end else begin
      up_q     <= btn_up;
      tog_q    <= btn_tog;
      dn_q     <= btn_dn;
      up_prev  <= up_q;
      tog_prev <= tog_q;
      dn_prev  <= dn_q;
      stage_q  <= stage_nxt;
      tgt_sx   <= tsx;
      tgt_ex   <= tex;
      tgt_sy   <= tsy;
      tgt_ey   <= tey;
      // Slewing reads the old registered target, so a coinciding tick uses it.
      if (SLEW == 0) begin
        cur_sx <= tgt_sx;
        cur_ex <= tgt_ex;
        cur_sy <= tgt_sy;
        cur_ey <= tgt_ey;
      end else if (frame_tick) begin
        cur_sx <= nsx;
        cur_ex <= nex;
        cur_sy <= nsy;
        cur_ey <= ney;
      end
    end
  end

  assign start_x = cur_sx;
  assign end_x   = cur_ex;
  assign start_y = cur_sy;
  assign end_y   = cur_ey;
  assign stage   = stage_q;
  assign busy    = (cur_sx != tgt_sx) | (cur_ex != tgt_ex) |
                   (cur_sy != tgt_sy) | (cur_ey != tgt_ey);

endmodule
